// File: rtl/mmio_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared types and constants for the MMIO bridge: FSM state
//               encoding, local register offsets, filler data and status
//               register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mmio_state_t;

    // Local register offsets from the window base
    localparam logic [15:0] OFS_LED  = 16'd0;
    localparam logic [15:0] OFS_SW   = 16'd1;
    localparam logic [15:0] OFS_STAT = 16'd2;
    localparam logic [15:0] OFS_RSVD = 16'd3;

    // Returned for unmapped reads, idle bus and timed-out channel reads
    localparam logic [15:0] JUNK_DATA = 16'hA5A5;

    // Status register layout
    localparam int STAT_TO_BIT   = 0;
    localparam int STAT_IDX_LSB  = 1;
    localparam int STAT_IDX_MSB  = 3;
    localparam int STAT_BUSY_BIT = 4;

endpackage
`default_nettype wire

// File: rtl/mmio_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge_if
// Description : CPU mm_* bus plus the req/ack peripheral channel bus. The
//               slave modport is the bridge's view; master is the view of
//               the CPU and peripherals surrounding it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_bridge_if #(
    parameter int NUM_CH  = 4,
    parameter int CH_SPAN = 4
);
    localparam int c_CH_AW = $clog2(CH_SPAN);

    logic [15:0]          mm_addr;
    logic                 mm_we;
    logic                 mm_re;
    logic [15:0]          mm_wdata;
    logic [15:0]          mm_rdata;
    logic                 mm_stall;

    logic [NUM_CH-1:0]    ch_req;
    logic                 ch_we;
    logic [c_CH_AW-1:0]   ch_addr;
    logic [15:0]          ch_wdata;
    logic [16*NUM_CH-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_ack;

    modport slave (
        input  mm_addr, mm_we, mm_re, mm_wdata,
        output mm_rdata, mm_stall,
        output ch_req, ch_we, ch_addr, ch_wdata,
        input  ch_rdata, ch_ack
    );

    modport master (
        output mm_addr, mm_we, mm_re, mm_wdata,
        input  mm_rdata, mm_stall,
        input  ch_req, ch_we, ch_addr, ch_wdata,
        output ch_rdata, ch_ack
    );

endinterface
`default_nettype wire

// File: rtl/mmio_bridge_sw_sync.sv
`default_nettype none
// ============================================================================
// Module      : sw_sync
// Description : Parametrised-width two-flop synchroniser for asynchronous
//               board inputs, synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_sync #(
    parameter int WIDTH = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Address-decoding hub between the CPU mm_* bus and the board.
//               Local LED/switch/status registers answer with zero wait;
//               NUM_CH peripheral channels are reached through a req/ack
//               handshake that stalls the CPU, bounded by a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          NUM_CH    = 4,
    parameter int          CH_SPAN   = 4,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 10,
    parameter int          TIMEOUT   = 255
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mmio_bridge_if.slave          bus,
    input  wire logic [SW_W-1:0]  sw_in,
    output logic      [LED_W-1:0] led_out
);

    localparam int c_CH_AW  = $clog2(CH_SPAN);
    localparam int c_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_CH_END = CH_SPAN * (NUM_CH + 1);

    mmio_state_t        r_state;
    logic [NUM_CH-1:0]  r_ch_req;
    logic               r_ch_we;
    logic [c_CH_AW-1:0] r_ch_addr;
    logic [15:0]        r_ch_wdata;
    logic [15:0]        r_cap;
    logic [2:0]         r_ch_idx;
    logic [2:0]         r_to_idx;
    logic               r_to_flag;
    logic [c_CNT_W-1:0] r_cnt;
    logic [LED_W-1:0]   r_led;

    logic [SW_W-1:0]    w_sw;
    logic [15:0]        w_ofs;
    logic [15:0]        w_slot;
    logic [2:0]         w_idx;
    logic               w_in_win;
    logic               w_loc;
    logic               w_ch_range;
    logic               w_wr;
    logic               w_rd;
    logic               w_ch_hit;
    logic               w_ack;
    logic               w_to;
    logic [15:0]        w_sel_rdata;
    logic [15:0]        w_status;
    logic [15:0]        w_rdata;

    sw_sync #(.WIDTH(SW_W)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .i_d (sw_in),
        .o_q (w_sw)
    );

    // Address decode. Local registers win over channel 0 if a small CH_SPAN
    // would make the two windows overlap.
    assign w_in_win   = (bus.mm_addr >= BASE_ADDR);
    assign w_ofs      = bus.mm_addr - BASE_ADDR;
    assign w_slot     = w_ofs >> c_CH_AW;
    assign w_idx      = 3'(w_slot - 16'd1);
    assign w_loc      = w_in_win && (w_ofs < 16'd4);
    assign w_ch_range = w_in_win && !w_loc && (w_ofs >= 16'(CH_SPAN))
                        && (w_ofs < 16'(c_CH_END));
    assign w_wr       = bus.mm_we;
    assign w_rd       = bus.mm_re && !bus.mm_we;

    // New channel accesses start only from IDLE, so RESP never re-launches
    assign w_ch_hit = (r_state == IDLE) && (bus.mm_we || bus.mm_re) && w_ch_range;
    assign w_ack    = (r_state == WAIT) && |(bus.ch_ack & r_ch_req);
    assign w_to     = (r_cnt == c_CNT_W'(TIMEOUT - 1));

    // Pick the read data of the channel currently being requested
    always_comb begin
        w_sel_rdata = JUNK_DATA;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_req[i]) begin
                w_sel_rdata = bus.ch_rdata[i*16 +: 16];
            end
        end
    end

    // Assemble the status word; unused bits read zero
    always_comb begin
        w_status = '0;
        w_status[STAT_TO_BIT]                  = r_to_flag;
        w_status[STAT_IDX_MSB:STAT_IDX_LSB]    = r_to_idx;
        w_status[STAT_BUSY_BIT]                = (r_state != IDLE);
    end

    // Read data mux: the RESP cycle returns the captured channel data
    always_comb begin
        w_rdata = JUNK_DATA;
        if (r_state == RESP) begin
            w_rdata = r_cap;
        end else if (w_rd && w_loc) begin
            case (w_ofs)
                OFS_LED:  w_rdata = 16'(r_led);
                OFS_SW:   w_rdata = 16'(w_sw);
                OFS_STAT: w_rdata = w_status;
                default:  w_rdata = JUNK_DATA;
            endcase
        end
    end

    // Local register writes and the channel handshake FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ch_req   <= '0;
            r_ch_we    <= 1'b0;
            r_ch_addr  <= '0;
            r_ch_wdata <= '0;
            r_cap      <= JUNK_DATA;
            r_ch_idx   <= '0;
            r_to_idx   <= '0;
            r_to_flag  <= 1'b0;
            r_cnt      <= '0;
            r_led      <= '0;
        end else begin
            if (w_wr && w_loc && (w_ofs == OFS_LED)) begin
                r_led <= bus.mm_wdata[LED_W-1:0];
            end
            // Clearing the sticky flag also forgets the recorded channel
            if (w_wr && w_loc && (w_ofs == OFS_STAT) && bus.mm_wdata[STAT_TO_BIT]) begin
                r_to_flag <= 1'b0;
                r_to_idx  <= '0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_ch_hit) begin
                        r_ch_idx   <= w_idx;
                        r_ch_addr  <= w_ofs[c_CH_AW-1:0];
                        r_ch_we    <= w_wr;
                        r_ch_wdata <= bus.mm_wdata;
                        r_ch_req   <= NUM_CH'(1) << w_idx;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        r_cap    <= r_ch_we ? JUNK_DATA : w_sel_rdata;
                        r_ch_req <= '0;
                        r_state  <= RESP;
                    end else if (w_to) begin
                        // Placed after the clear so a timeout is never lost
                        r_to_flag <= 1'b1;
                        r_to_idx  <= r_ch_idx;
                        r_cap     <= JUNK_DATA;
                        r_ch_req  <= '0;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mm_rdata = w_rdata;
    assign bus.mm_stall = w_ch_hit || (r_state == WAIT);
    assign bus.ch_req   = r_ch_req;
    assign bus.ch_we    = r_ch_we;
    assign bus.ch_addr  = r_ch_addr;
    assign bus.ch_wdata = r_ch_wdata;
    assign led_out      = r_led;

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU's `mm_*` bus and board/peripheral resources. It replaces hand-written top-level address decode with a configurable hub:
- local LED, switch and status registers;
- `NUM_CH` peripheral channels (SPART, BMP display, …) behind a req/ack handshake, with CPU stall and a per-access timeout.

It sits directly between `cpu` and the peripherals in the top level.

## Interface
- `BASE_ADDR`, 16'hC000, base of the I/O window
- `NUM_CH`, 4, number of handshaked peripheral channels (1–8)
- `CH_SPAN`, 4, addresses per channel (power of 2, ≥2)
- `LED_W`, 10, LED register width
- `SW_W`, 10, switch input width
- `TIMEOUT`, 255, max cycles waiting for `ch_ack` (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `mm_addr`  in  16  CPU address
- `mm_we`  in  1  CPU write strobe
- `mm_re`  in  1  CPU read strobe
- `mm_wdata`  in  16  CPU write data
- `mm_rdata`  out  16  read data to CPU
- `mm_stall`  out  1  holds CPU while a channel access is pending
- `ch_req`  out  NUM_CH  one-hot channel request
- `ch_we`  out  1  1 = write, 0 = read (valid with `ch_req`)
- `ch_addr`  out  $clog2(CH_SPAN)  offset within channel
- `ch_wdata`  out  16  write data (valid with `ch_req`)
- `ch_rdata`  in  16*NUM_CH  per-channel read data, valid with `ch_ack`
- `ch_ack`  in  NUM_CH  per-channel completion
- `sw_in`  in  SW_W  raw asynchronous switches
- `led_out`  out  LED_W  LED register

## Operation
- Local map, all zero-wait:
  - BASE+0: LED register, R/W; writes take `mm_wdata[LED_W-1:0]`.
  - BASE+1: switches, RO, zero-extended.
  - BASE+2: status, R/W1C.
  - BASE+3: reserved; reads return 16'hA5A5.
- Channel k window: BASE + CH_SPAN*(k+1) … BASE + CH_SPAN*(k+2) − 1. With defaults, ch0 = C004–C007 and ch1 = C008–C00B.
- Unmapped read, or read with no strobe: `mm_rdata` = 16'hA5A5. Unmapped writes are dropped.
- `mm_we` and `mm_re` both high: treated as a write.
- Status register bits:
  - [0] timeout, sticky; cleared by writing 1 to bit 0.
  - [3:1] channel index of the last timeout.
  - [4] busy (state ≠ IDLE).
  - Other bits read 0.
- FSM states IDLE → WAIT → RESP → IDLE.
  - **IDLE**, channel hit: latch k, offset, we, wdata. Go to WAIT.
  - **WAIT**: `ch_req[k]`=1 with stable `ch_we`/`ch_addr`/`ch_wdata`.
    - `ch_ack[k]`: capture `ch_rdata[k]` (reads only). Go to RESP.
    - Counter reaches TIMEOUT: set timeout bit and index, captured data = 16'hA5A5, go to RESP.
  - **RESP**: one cycle. `mm_rdata` = captured data. Re-access is suppressed. Go to IDLE.
- `mm_stall` = (IDLE & channel hit) | WAIT. It is low in RESP, which is the CPU's completion cycle.
- Acks from non-selected channels, or any ack outside WAIT, are ignored.
- Ack and timeout in the same cycle: ack wins, status unchanged.
- Local register accesses never stall, in any state.

## Timing
- Reset values: `led_out`=0, `ch_req`=0, `ch_we`=0, `ch_addr`=0, `ch_wdata`=0, status=0, state=IDLE, counter=0, `mm_stall`=0 (strobes low). Switch synchroniser stages = 0.
- Switches pass a 2-flop synchroniser: a switch change is visible on a read 2 cycles later.
- LED write is visible on `led_out` the cycle after the write strobe.
- Channel latency:
  - `ch_req` rises 1 cycle after the access is presented.
  - Ack at WAIT cycle n gives RESP at n+1.
  - Minimum CPU stall is 2 cycles (ack in the first WAIT cycle).
- Timeout: `ch_req` drops after TIMEOUT WAIT cycles. RESP follows the next cycle, for a total stall of TIMEOUT+1.
- Reset mid-access: `ch_req` drops the next edge, FSM returns to IDLE, no response is generated.

## Structure
- Package `mmio_pkg`:
  - state enum `mmio_state_t` {IDLE, WAIT, RESP};
  - local offsets `OFS_LED`=0, `OFS_SW`=1, `OFS_STAT`=2;
  - `JUNK_DATA`=16'hA5A5;
  - status bit positions.
- One sub-module, `sw_sync`: a parametrised-width 2-flop synchroniser with synchronous active-high reset.

## Test plan
- Reset, then write 16'h03FF to C000 → `led_out`=10'h3FF next cycle; read C000 → 16'h03FF with no stall.
- Set `sw_in`=10'h155, wait 2 cycles, read C001 → 16'h0155. Read C003 → 16'hA5A5.
- Read C005 with ch0 acking on its 2nd request cycle with 16'h1234:
  - `ch_req`=0001, `ch_addr`=1, `ch_we`=0;
  - `mm_stall` high for 3 cycles;
  - RESP `mm_rdata`=16'h1234.
- Write 16'h00AB to C009, ch1 acks immediately → `ch_req`=0010, `ch_wdata`=16'h00AB, `ch_addr`=1, stall 2 cycles. An ack on ch2 during the access is ignored.
- Read C00C with ch2 never acking and TIMEOUT=8:
  - `ch_req` drops after 8 WAIT cycles;
  - `mm_rdata`=16'hA5A5;
  - status reads 16'h0005;
  - write 1 to C002 → status 0.
- Assert `rst` during WAIT → `ch_req`=0 and state IDLE next cycle; `led_out`=0; a subsequent local read proceeds normally.
